// File: rtl/ddr3_rd_checker.sv
// ddr3_rd_checker
//   Checks the AXI read-data stream returned by the DDR3 controller during the
//   memory test. Beat N of a pass must carry N (mod 2^CNT_W) in its low CNT_W
//   bits and, when CHK_UPPER is set, zeros above. Burst framing (rlast) is
//   checked against a free-running burst-beat counter. Error statistics are
//   kept for LEDs and the debugger.
//
// Ports
//   i_clk         controller core clock, rising edge
//   i_rst         synchronous active-high reset
//   i_start       one-cycle pulse: clear statistics, arm a checking pass
//   i_rvalid      read beat valid (always accepted)
//   i_rdata       read beat data
//   i_rlast       last beat of burst
//   o_busy        pass armed, beats being checked
//   o_done        pass complete, held until next i_start or reset
//   o_err         sticky: any data or framing error this pass
//   o_err_cnt     mismatching beat count, saturating
//   o_frame_err   sticky: rlast misplaced or stray beat while not checking
//   o_beat_cnt    beats compared this pass
//   o_first_idx   index of the first mismatching beat
//   o_first_data  low CNT_W bits of the first mismatching beat
module ddr3_rd_checker #(
  parameter int DATA_W     = 256,
  parameter int CNT_W      = 26,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 2097151,
  parameter int CHK_UPPER  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_rvalid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_err_cnt,
  output logic              o_frame_err,
  output logic [31:0]       o_beat_cnt,
  output logic [31:0]       o_first_idx,
  output logic [CNT_W-1:0]  o_first_data
);

  localparam int BB_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BB_W-1:0] LAST_BEAT = BB_W'(BURST_LEN - 1);
  localparam logic [31:0]     LAST_IDX  = 32'(NUM_BURSTS * BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FLUSH, S_DONE} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  exp_cnt;
  logic [BB_W-1:0]   burst_cnt;
  logic [31:0]       acc_cnt;

  logic              vld_p1;
  logic              frame_bad_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic [CNT_W-1:0]  exp_p1;

  logic accept;
  logic stray;
  logic start_ok;
  logic last_pos;
  logic pass_end;
  logic mismatch_p1;

  assign accept   = (state == S_CHECK) && i_rvalid;
  assign stray    = i_rvalid && (state != S_CHECK);
  assign start_ok = i_start && ((state == S_IDLE) || (state == S_DONE));
  assign last_pos = (burst_cnt == LAST_BEAT);
  assign pass_end = accept && (acc_cnt == LAST_IDX);

  assign mismatch_p1 = (rdata_p1[CNT_W-1:0] != exp_p1) ||
                       ((CHK_UPPER != 0) && (|rdata_p1[DATA_W-1:CNT_W]));

  // Stage 1: capture the beat and what it should have been
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rdata_p1     <= i_rdata;
      exp_p1       <= exp_cnt;
      frame_bad_p1 <= i_rlast ^ last_pos;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      exp_cnt      <= '0;
      burst_cnt    <= '0;
      acc_cnt      <= '0;
      vld_p1       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= '0;
      o_frame_err  <= 1'b0;
      o_beat_cnt   <= '0;
      o_first_idx  <= '0;
      o_first_data <= '0;
    end else begin
      vld_p1 <= accept;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state  <= S_CHECK;
            o_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          if (pass_end) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // last beat's compare lands on this edge, so done rises with it
          state  <= S_DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // Counters are deliberately not resynchronised on a framing error
      if (accept) begin
        exp_cnt   <= exp_cnt + 1'b1;
        burst_cnt <= last_pos ? '0 : burst_cnt + 1'b1;
        acc_cnt   <= acc_cnt + 32'd1;
      end

      // Stage 2: compare the registered beat
      if (vld_p1) begin
        o_beat_cnt <= o_beat_cnt + 32'd1;
        if (mismatch_p1) begin
          o_err_cnt <= sat_inc16(o_err_cnt);
          o_err     <= 1'b1;
          if (o_err_cnt == 16'd0) begin
            o_first_idx  <= o_beat_cnt;
            o_first_data <= rdata_p1[CNT_W-1:0];
          end
        end
        if (frame_bad_p1) begin
          o_frame_err <= 1'b1;
          o_err       <= 1'b1;
        end
      end

      if (start_ok) begin
        exp_cnt      <= '0;
        burst_cnt    <= '0;
        acc_cnt      <= '0;
        o_done       <= 1'b0;
        o_err        <= 1'b0;
        o_err_cnt    <= '0;
        o_frame_err  <= 1'b0;
        o_beat_cnt   <= '0;
        o_first_idx  <= '0;
        o_first_data <= '0;
      end

      // A beat arriving while no pass is being checked is a framing fault
      if (stray) begin
        o_frame_err <= 1'b1;
        o_err       <= 1'b1;
      end
    end
  end

endmodule
